crc_frame_appender: RTL

Byte-stream frame controller that sequences one crc_calc engine per frame. Forwards each input frame unchanged, then appends the CRC (FCS) bytes and moves m_last_o onto the final CRC byte. Re-initialises the engine between frames. Sits on the TX side between the frame source and the serialiser/MAC.

---
 rtl/crc_frame_pkg.sv | 20 ++
 rtl/crc_frame_appender_crc_calc.sv | 56 +++++
 rtl/crc_frame_appender.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/crc_frame_pkg.sv
// Shared types and constants for the CRC frame appender.
package crc_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    APPEND = 2'd2
  } state_t;

  // Ethernet CRC-32 (reflected, inverted)
  localparam int unsigned ETH_CRC_SIZE = 32;
  localparam logic [63:0] ETH_POLY     = 64'h0000_0000_04C1_1DB7;
  localparam logic [63:0] ETH_INIT     = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] ETH_XOR_OUT  = 64'h0000_0000_FFFF_FFFF;

  function automatic int unsigned crc_bytes(input int unsigned crc_size);
    return crc_size / 8;
  endfunction

endpackage

// File: rtl/crc_frame_appender_crc_calc.sv
// Parameterised bytewise CRC engine; crc_o is the finalised (reflected/XORed) value of the running register.
module crc_calc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CRC_SIZE   = 32,
  parameter logic [63:0] POLY       = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] INIT       = 64'h0000_0000_FFFF_FFFF,
  parameter string       REF_IN     = "TRUE",
  parameter string       REF_OUT    = "TRUE",
  parameter logic [63:0] XOR_OUT    = 64'h0000_0000_FFFF_FFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  localparam logic [CRC_SIZE-1:0] POLY_C  = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] INIT_C  = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] XOR_C   = XOR_OUT[CRC_SIZE-1:0];
  localparam bit                  REF_IN_B  = (REF_IN == "TRUE");
  localparam bit                  REF_OUT_B = (REF_OUT == "TRUE");

  logic [DATA_WIDTH-1:0] din;
  logic [CRC_SIZE-1:0]   crc_q, crc_d, crc_rev;

  always_comb begin
    din = data_i;
    if (REF_IN_B) begin
      for (int i = 0; i < int'(DATA_WIDTH); i++) din[i] = data_i[int'(DATA_WIDTH) - 1 - i];
    end
  end

  // MSB-first shift register update, one data bit per step
  always_comb begin
    crc_d = crc_q;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (din[i] ^ crc_d[CRC_SIZE-1]) crc_d = {crc_d[CRC_SIZE-2:0], 1'b0} ^ POLY_C;
      else                            crc_d = {crc_d[CRC_SIZE-2:0], 1'b0};
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CRC_SIZE); i++) crc_rev[i] = crc_q[int'(CRC_SIZE) - 1 - i];
  end

  assign crc_o = (REF_OUT_B ? crc_rev : crc_q) ^ XOR_C;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             crc_q <= INIT_C;
    else if (soft_reset_i) crc_q <= INIT_C;
    else if (valid_i)      crc_q <= crc_d;
  end

endmodule

// File: rtl/crc_frame_appender.sv
// Forwards a byte frame unchanged, then appends its CRC bytes with m_last_o on the final one.
module crc_frame_appender
  import crc_frame_pkg::*;
#(
  parameter logic [63:0] POLY      = ETH_POLY,
  parameter int unsigned CRC_SIZE  = ETH_CRC_SIZE,
  parameter logic [63:0] INIT      = ETH_INIT,
  parameter string       REF_IN    = "TRUE",
  parameter string       REF_OUT   = "TRUE",
  parameter logic [63:0] XOR_OUT   = ETH_XOR_OUT,
  parameter string       LSB_FIRST = "TRUE"
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       busy_o
);

  localparam int unsigned     CRC_BYTES = crc_bytes(CRC_SIZE);
  localparam int unsigned     CNT_W     = (CRC_BYTES > 1) ? $clog2(CRC_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_BYTES - 1);
  localparam bit              LSB_B     = (LSB_FIRST == "TRUE");

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;

  logic                out_free, s_ready_c, eng_valid, eng_soft_reset;
  logic [CRC_SIZE-1:0] crc;
  logic [CNT_W-1:0]    byte_idx;
  logic [7:0]          crc_byte;

  crc_calc #(
    .DATA_WIDTH (8),
    .CRC_SIZE   (CRC_SIZE),
    .POLY       (POLY),
    .INIT       (INIT),
    .REF_IN     (REF_IN),
    .REF_OUT    (REF_OUT),
    .XOR_OUT    (XOR_OUT)
  ) u_crc (
    .clk_i        (clk_i),
    .rst_i        (~rst_i),
    .soft_reset_i (eng_soft_reset),
    .valid_i      (eng_valid),
    .data_i       (s_data_i),
    .crc_o        (crc)
  );

  assign out_free = !valid_q || m_ready_i;
  assign byte_idx = LSB_B ? cnt_q : (CNT_LAST - cnt_q);
  assign crc_byte = 8'(crc >> {byte_idx, 3'b000});

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    valid_d        = valid_q;
    last_d         = last_q;
    busy_d         = busy_q;
    s_ready_c      = 1'b0;
    eng_valid      = 1'b0;
    eng_soft_reset = 1'b0;

    if (valid_q && m_ready_i && last_q) busy_d = 1'b0;
    // Output slot drains unless a new byte is loaded below
    if (out_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        s_ready_c = out_free;
        if (s_valid_i && out_free) begin
          eng_valid = 1'b1;
          data_d    = s_data_i;
          valid_d   = 1'b1;
          last_d    = 1'b0;
          busy_d    = 1'b1;
          if (s_last_i) begin
            state_d = APPEND;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      APPEND: begin
        if (out_free) begin
          data_d  = crc_byte;
          valid_d = 1'b1;
          last_d  = (cnt_q == CNT_LAST);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            eng_soft_reset = 1'b1;
            state_d        = IDLE;
            cnt_d          = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign s_ready_o = s_ready_c;
  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;
  assign busy_o    = busy_q;

endmodule
